softmax_ctrl: RTL and testbench
===============================

SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 8, the width of every address port.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one softmax pass; sampled in IDLE only.
REQ-005 SHALL have ports start_addr, end_addr  input  ADDRSIZE  first and last memory word address; both sampled when start is accepted.
REQ-006 SHALL have ports max_addr, sub0_addr, sub1_addr  output  ADDRSIZE  read addresses for the max, first-subtract and pre-subtract memory ports.
REQ-007 SHALL have port clr  output  1  one-cycle pulse that clears the max and accumulator registers.
REQ-008 SHALL have ports max_en, sub0_en, exp_en, acc_en, log_en, presub_en, logsub_en, exp2_en  output  1 each  datapath stage enables.
REQ-009 SHALL have ports out_valid, busy, done, err  output  1 each  output-word strobe, pass in progress, end-of-pass pulse, and bad-range flag.

Function
REQ-010 SHALL implement states IDLE, MAX, SUB, DRAIN, LOG, PRESUB, ODRAIN and DONE.
REQ-011 In IDLE with start=1 and end_addr>=start_addr, SHALL pulse clr, latch N=end_addr-start_addr+1 and the range, and enter MAX in the next cycle.
REQ-012 In IDLE with start=1 and end_addr<start_addr, SHALL enter DONE directly with no stage enables, and SHALL set err in the next cycle.
REQ-013 MAX SHALL last N cycles, assert max_en, and drive max_addr from start_addr up to end_addr, one word per cycle; the next state is SUB.
REQ-014 SUB SHALL last N cycles, assert sub0_en, and step sub0_addr through the same range; exp_en SHALL follow sub0_en delayed by 1 cycle, and acc_en SHALL follow it delayed by 2 cycles.
REQ-015 DRAIN SHALL last 2 cycles so the exp_en and acc_en tails complete; the next state is LOG.
REQ-016 LOG SHALL last 1 cycle with log_en=1; the next state is PRESUB.
REQ-017 PRESUB SHALL last N cycles, assert presub_en, and step sub1_addr through the range; logsub_en, exp2_en and out_valid SHALL follow presub_en delayed by 1, 2 and 3 cycles respectively.
REQ-018 ODRAIN SHALL last 3 cycles; the next state is DONE.
REQ-019 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy=1 SHALL be ignored, and start_addr/end_addr changes after acceptance SHALL have no effect.
REQ-022 Address counters SHALL not wrap: when end_addr equals 2^ADDRSIZE-1, the last address issued SHALL be end_addr and the counter SHALL stop there.
REQ-023 When idle, addresses SHALL hold their last value, and all enables SHALL be 0.
REQ-024 err SHALL clear when the next start is accepted.
REQ-025 Total pass length from start acceptance to the done pulse SHALL be 3N+7 cycles.

Reset
REQ-026 With reset=1 at a clock edge, the state SHALL become IDLE, and all enables, clr, out_valid, busy, done and err SHALL become 0.
REQ-027 With reset=1 at a clock edge, all address outputs SHALL become 0.
REQ-028 A reset asserted mid-pass SHALL abort the pass, with no done pulse issued.

Configuration
REQ-029 With SOFTMAX_CTRL_PERF_EN defined, SHALL add output cycles[31:0], which counts cycles with busy=1 in the current pass, holds after done, clears on start acceptance and on reset, and saturates at all-ones.
REQ-030 Without SOFTMAX_CTRL_PERF_EN, the cycles port and its counter SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-031 start_addr=4, end_addr=7, start in cycle 0 -> clr in cycle 0; max_en in cycles 1-4 with addr 4..7; sub0_en in 5-8; exp_en in 6-9; acc_en in 7-10.
REQ-032 Same pass -> log_en in cycle 11; presub_en in 12-15 with sub1_addr 4..7; out_valid in 15-18; done in 19; busy low from cycle 20.
REQ-033 start_addr=9, end_addr=3 -> no enables, done pulse in cycle 1, err=1 from cycle 2 until the next accepted start.
REQ-034 start_addr=end_addr=0xFF (N=1) -> one address per phase with no wrap; done at cycle 10.
REQ-035 Reset asserted in cycle 6 of the REQ-031 pass -> all outputs 0 in cycle 7; no done pulse; a new start is accepted afterwards.
REQ-036 start held high for the full REQ-031 pass -> exactly one pass; the next pass begins at cycle 20; with SOFTMAX_CTRL_PERF_EN defined, cycles=19 after the first pass.

Source files
------------

// File: rtl/softmax_ctrl.sv
// softmax_ctrl: sequencer for a three-phase softmax pass over a contiguous
// memory range.
// Phases: running max, subtract/exp/accumulate, log, and a second
// subtract/exp pass that produces the output words.
//
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start                 : begin a pass (sampled in IDLE only)
//   start_addr, end_addr  : inclusive word range, latched on acceptance
//   max_addr, sub0_addr, sub1_addr : read addresses for the three read ports
//   clr                   : one-cycle clear of the max/accumulator registers
//   max_en .. exp2_en     : datapath stage enables
//   out_valid             : output word strobe
//   busy                  : high while a pass is in progress
//   done                  : one-cycle pulse at the end of a pass
//   err                   : set when the last pass had end_addr < start_addr
//   cycles                : busy-cycle count of the current pass
//                           (only with SOFTMAX_CTRL_PERF_EN defined)
//
// Build option: define SOFTMAX_CTRL_PERF_EN to add the cycles counter.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; enables low, addresses hold
// MAX    | N cycles, max_en, max_addr walks the range
// SUB    | N cycles, sub0_en, sub0_addr walks the range
// DRAIN  | 2 cycles, lets the exp_en/acc_en tails finish
// LOG    | 1 cycle, log_en
// PRESUB | N cycles, presub_en, sub1_addr walks the range
// ODRAIN | 3 cycles, lets logsub_en/exp2_en/out_valid tails finish
// DONE   | 1 cycle, done pulse (also entered directly on a bad range)
module softmax_ctrl #(
  parameter int ADDRSIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] start_addr,
  input  logic [ADDRSIZE-1:0] end_addr,
  output logic [ADDRSIZE-1:0] max_addr,
  output logic [ADDRSIZE-1:0] sub0_addr,
  output logic [ADDRSIZE-1:0] sub1_addr,
  output logic                clr,
  output logic                max_en,
  output logic                sub0_en,
  output logic                exp_en,
  output logic                acc_en,
  output logic                log_en,
  output logic                presub_en,
  output logic                logsub_en,
  output logic                exp2_en,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef SOFTMAX_CTRL_PERF_EN
  ,
  output logic [31:0]         cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE, MAX, SUB, DRAIN, LOG, PRESUB, ODRAIN, DONE
  } state_t;

  localparam logic [ADDRSIZE-1:0] A_ZERO = '0;
  localparam logic [ADDRSIZE-1:0] A_ONE  = ADDRSIZE'(1);
  localparam logic [ADDRSIZE-1:0] A_TWO  = ADDRSIZE'(2);

  state_t              state, state_nxt;
  logic [ADDRSIZE-1:0] cnt, cnt_nxt;
  logic [ADDRSIZE-1:0] start_r, end_r, span_r;
  logic                bad_r;
  logic                accept, range_ok, cnt_tc;

  assign accept   = (state == IDLE) && start;
  assign range_ok = (end_addr >= start_addr);
  assign cnt_tc   = (cnt == A_ZERO);

  // Phase timer: a down-counter loaded with (phase length - 1); span_r
  // already equals N-1 for the range-length phases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = 1'b0;
    max_en    = 1'b0;
    sub0_en   = 1'b0;
    log_en    = 1'b0;
    presub_en = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    if (state != IDLE && !cnt_tc) cnt_nxt = cnt - A_ONE;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (range_ok) begin
            clr       = !reset;
            state_nxt = MAX;
            cnt_nxt   = end_addr - start_addr;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      MAX: begin
        max_en = 1'b1;
        if (cnt_tc) begin
          state_nxt = SUB;
          cnt_nxt   = span_r;
        end
      end
      SUB: begin
        sub0_en = 1'b1;
        if (cnt_tc) begin
          state_nxt = DRAIN;
          cnt_nxt   = A_ONE;
        end
      end
      DRAIN: begin
        if (cnt_tc) state_nxt = LOG;
      end
      LOG: begin
        log_en    = 1'b1;
        state_nxt = PRESUB;
        cnt_nxt   = span_r;
      end
      PRESUB: begin
        presub_en = 1'b1;
        if (cnt_tc) begin
          state_nxt = ODRAIN;
          cnt_nxt   = A_TWO;
        end
      end
      ODRAIN: begin
        if (cnt_tc) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= A_ZERO;
      start_r   <= A_ZERO;
      end_r     <= A_ZERO;
      span_r    <= A_ZERO;
      bad_r     <= 1'b0;
      err       <= 1'b0;
      max_addr  <= A_ZERO;
      sub0_addr <= A_ZERO;
      sub1_addr <= A_ZERO;
      exp_en    <= 1'b0;
      acc_en    <= 1'b0;
      logsub_en <= 1'b0;
      exp2_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        start_r <= start_addr;
        end_r   <= end_addr;
        span_r  <= end_addr - start_addr;
        bad_r   <= !range_ok;
        err     <= 1'b0;
      end else if (state == DONE && bad_r) begin
        err <= 1'b1;
      end

      // Address walkers stop at end_r so a range ending at the top of the
      // address space never wraps back to zero.
      if (accept && range_ok)
        max_addr <= start_addr;
      else if (max_en && max_addr != end_r)
        max_addr <= max_addr + A_ONE;

      if (state == MAX && cnt_tc)
        sub0_addr <= start_r;
      else if (sub0_en && sub0_addr != end_r)
        sub0_addr <= sub0_addr + A_ONE;

      if (state == LOG)
        sub1_addr <= start_r;
      else if (presub_en && sub1_addr != end_r)
        sub1_addr <= sub1_addr + A_ONE;

      exp_en    <= sub0_en;
      acc_en    <= exp_en;
      logsub_en <= presub_en;
      exp2_en   <= logsub_en;
      out_valid <= exp2_en;
    end
  end

`ifdef SOFTMAX_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset || accept)
      cycles <= '0;
    else if (busy && cycles != 32'hFFFF_FFFF)
      cycles <= cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_softmax_ctrl.sv
module tb_softmax_ctrl;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] start_addr, end_addr;
  logic [AW-1:0] max_addr, sub0_addr, sub1_addr;
  logic          clr, max_en, sub0_en, exp_en, acc_en, log_en, presub_en;
  logic          logsub_en, exp2_en, out_valid, busy, done, err;
`ifdef SOFTMAX_CTRL_PERF_EN
  logic [31:0]   cycles;
`endif

  softmax_ctrl #(.ADDRSIZE(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .start_addr(start_addr), .end_addr(end_addr),
    .max_addr(max_addr), .sub0_addr(sub0_addr), .sub1_addr(sub1_addr),
    .clr(clr), .max_en(max_en), .sub0_en(sub0_en), .exp_en(exp_en),
    .acc_en(acc_en), .log_en(log_en), .presub_en(presub_en),
    .logsub_en(logsub_en), .exp2_en(exp2_en), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
`ifdef SOFTMAX_CTRL_PERF_EN
    , .cycles(cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state carried between passes.
  logic [AW-1:0] exp_max = '0, exp_sub0 = '0, exp_sub1 = '0;
  logic          exp_err = 1'b0;
  int            exp_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dut_flags();
    return {clr, max_en, sub0_en, exp_en, acc_en, log_en, presub_en,
            logsub_en, exp2_en, out_valid, busy, done};
  endfunction

  function automatic bit win(input int t, input int a, input int b);
    return (t >= a) && (t <= b);
  endfunction

  // Expected flag vector t cycles after acceptance, from the phase schedule.
  function automatic logic [11:0] exp_flags(input int t, input int n, input bit good);
    if (!good) return {10'b0, (t == 1), (t == 1)};
    return {(t == 0),
            win(t, 1, n),
            win(t, n + 1, 2 * n),
            win(t, n + 2, 2 * n + 1),
            win(t, n + 3, 2 * n + 2),
            (t == 2 * n + 3),
            win(t, 2 * n + 4, 3 * n + 3),
            win(t, 2 * n + 5, 3 * n + 4),
            win(t, 2 * n + 6, 3 * n + 5),
            win(t, 2 * n + 7, 3 * n + 6),
            win(t, 1, 3 * n + 7),
            (t == 3 * n + 7)};
  endfunction

  task automatic idle_check(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("idle_flags", 32'(dut_flags()), 32'd0);
      chk("idle_max_addr", 32'(max_addr), 32'(exp_max));
      chk("idle_sub0_addr", 32'(sub0_addr), 32'(exp_sub0));
      chk("idle_sub1_addr", 32'(sub1_addr), 32'(exp_sub1));
      chk("idle_err", 32'(err), 32'(exp_err));
`ifdef SOFTMAX_CTRL_PERF_EN
      chk("idle_cycles", cycles, 32'(exp_cycles));
`endif
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge; start is asserted for the next cycle (t=0).
  task automatic run_pass(input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input bit hold, input bit noise, input int abort_at);
    bit good;
    int n, len;
    good = (e >= s);
    n    = good ? (int'(e) - int'(s) + 1) : 0;
    len  = good ? 3 * n + 7 : 1;
    start = 1'b1;
    start_addr = s;
    end_addr = e;
    for (int t = 0; t <= len; t++) begin
      if (t == abort_at) reset = 1'b1;
      @(negedge clk);
      chk($sformatf("flags s=%0d e=%0d t=%0d", s, e, t), 32'(dut_flags()),
          32'(exp_flags(t, n, good)));
      chk($sformatf("err t=%0d", t), 32'(err), (t == 0) ? 32'(exp_err) : 32'd0);
      if (t == 0) begin
        chk("hold_max_addr", 32'(max_addr), 32'(exp_max));
`ifdef SOFTMAX_CTRL_PERF_EN
        chk("cycles_prev_pass", cycles, 32'(exp_cycles));
`endif
      end
      if (good && win(t, 1, n))
        chk($sformatf("max_addr t=%0d", t), 32'(max_addr), 32'(int'(s) + t - 1));
      if (good && win(t, n + 1, 2 * n))
        chk($sformatf("sub0_addr t=%0d", t), 32'(sub0_addr), 32'(int'(s) + t - n - 1));
      if (good && win(t, 2 * n + 4, 3 * n + 3))
        chk($sformatf("sub1_addr t=%0d", t), 32'(sub1_addr), 32'(int'(s) + t - 2 * n - 4));
      if (t == abort_at) break;
      @(posedge clk); #1;
      if (!hold) begin
        start = (noise && t < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        start_addr = AW'($urandom);
        end_addr = AW'($urandom);
      end
    end
    if (abort_at >= 0) begin
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      exp_max = '0; exp_sub0 = '0; exp_sub1 = '0;
      exp_err = 1'b0; exp_cycles = 0;
      @(negedge clk);
      chk("abort_flags", 32'(dut_flags()), 32'd0);
      chk("abort_addrs", {8'd0, max_addr, sub0_addr, sub1_addr}, 32'd0);
      chk("abort_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        @(posedge clk); #1;
      end
    end else begin
      if (good) begin
        exp_max = e; exp_sub0 = e; exp_sub1 = e;
        exp_err = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
      exp_cycles = len;
    end
  endtask

  initial begin
    logic [AW-1:0] s, e;
    reset = 1'b1;
    start = 1'b1;
    start_addr = 8'd3;
    end_addr = 8'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset_addrs", {8'd0, max_addr, sub0_addr, sub1_addr}, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    idle_check(2);

    run_pass(8'd4, 8'd7, 1'b0, 1'b0, -1);
    idle_check(2);
    run_pass(8'd9, 8'd3, 1'b0, 1'b0, -1);
    idle_check(3);
    run_pass(8'hFF, 8'hFF, 1'b0, 1'b0, -1);
    idle_check(2);
    run_pass(8'd4, 8'd7, 1'b0, 1'b0, 6);
    idle_check(2);
    run_pass(8'd4, 8'd7, 1'b0, 1'b0, -1);
    idle_check(1);
    run_pass(8'd4, 8'd7, 1'b1, 1'b0, -1);
    run_pass(8'd4, 8'd7, 1'b0, 1'b0, -1);
    idle_check(2);
    run_pass(8'hF9, 8'hFF, 1'b0, 1'b1, -1);
    idle_check(1);

    for (int k = 0; k < 12; k++) begin
      s = AW'($urandom);
      if ($urandom_range(0, 5) == 0 && s != 8'd0)
        e = AW'($urandom_range(0, int'(s) - 1));
      else if (int'(s) + 7 > 255)
        e = AW'($urandom_range(int'(s), 255));
      else
        e = s + AW'($urandom_range(0, 7));
      run_pass(s, e, 1'b0, 1'b1, -1);
      idle_check(1 + int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
